instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the RISC-V core. Owns the PC register and issues word fetches to instruction memory over a valid/ready request channel.
- Captures each response and presents the instruction, with its PC and PC+4, to decode over a valid/ready handshake.
- The instruction field feeds the immediate extender directly.
- Redirects from branch/jump resolution (PC + extended immediate, or the JALR target) retarget fetch and squash the in-flight or held instruction.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: value on instr while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  one-cycle pulse: take redirect_pc.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored, PC bits [1:0] always 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; memory must accept it unconditionally.
- imem_rsp_data  in  32  fetched instruction word.
- instr_valid  out  1  held instruction valid to decode.
- instr_ready  in  1  decode accepts instruction.
- instr  out  32  instruction word (NOP_INSTR when not valid).
- instr_pc  out  32  PC of instr.
- instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32.
- fetch_count  out  32  count of instructions accepted by decode; wraps.

Behaviour:
- All outputs are registered. There is at most one outstanding memory request.
- Reset values:
  - state IDLE, pc = RESET_PC
  - imem_req_valid = 0, imem_req_addr = RESET_PC
  - instr_valid = 0, instr = NOP_INSTR, instr_pc = RESET_PC, instr_pc_plus4 = RESET_PC + 4
  - fetch_count = 0
- State machine:
  - IDLE: always -> REQ on the next cycle. IDLE exists only to give one clean cycle after reset.
  - REQ: imem_req_valid = 1, imem_req_addr = pc.
    - On req handshake -> WAIT.
    - Addr and valid stay stable while ready = 0.
  - WAIT: awaiting the response.
    - On imem_rsp_valid: load instr = rsp_data, instr_pc = pc, instr_pc_plus4 = pc + 4, instr_valid = 1 -> HOLD.
  - HOLD: instr_valid = 1; outputs stable until accepted.
    - On instr_ready: instr_valid = 0, instr = NOP_INSTR, pc = pc + 4, fetch_count++ -> REQ.
  - DRAIN: one response is outstanding and must be discarded.
    - On imem_rsp_valid, drop the data -> REQ.
- Latency: first request 1 cycle after reset release; instr_valid rises 1 cycle after the response beat. With zero-wait memory, throughput is one instruction per 4 cycles.
- Redirect handling (pc <= {redirect_pc[31:2], 2'b00} in every case; redirect has priority over all other events):
  - IDLE or REQ, no handshake: stay or move to REQ; address updates the next cycle. No request is issued for the old pc.
  - REQ with a same-cycle req handshake: the request counts as issued -> DRAIN.
  - WAIT without rsp_valid -> DRAIN. WAIT with a same-cycle rsp_valid: response discarded -> REQ.
  - HOLD: held instruction squashed, instr_valid = 0, no fetch_count increment even if instr_ready = 1 the same cycle -> REQ.
  - DRAIN: stays DRAIN with the new pc.
- imem_rsp_valid is ignored in IDLE, REQ and HOLD (stale beats after a mid-operation reset are dropped).
- pc + 4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset asserted mid-operation returns everything to reset values immediately (async), including an instruction that is being held.

Test Plan:
- Reset release, zero-wait memory, instr_ready = 1 -> req addr 0x0 at cycle 1, 0x4 at cycle 5; instr_pc 0x0 then 0x4; fetch_count = 2 after cycle 8.
- Hold imem_req_ready = 0 for 3 cycles at pc 0x8 -> req_valid = 1 and addr 0x8 are stable all 3 cycles; exactly one WAIT follows.
- Decode stalls (instr_ready = 0) for 5 cycles holding 0x00500093 -> instr, instr_pc and instr_pc_plus4 are unchanged; no new request is issued.
- Redirect to 0x103 while in WAIT, response arrives 2 cycles later -> response discarded, next request addr 0x100, next instr_pc 0x100.
- Redirect to 0x40 in HOLD with instr_ready = 1 the same cycle -> fetch_count unchanged, instr_valid = 0, next request addr 0x40.
- pc = 0xFFFF_FFFC accepted -> instr_pc_plus4 = 0x0 and the next request addr is 0x0. Then assert rst mid-WAIT -> outputs return to reset values, and a later stray rsp_valid is ignored.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage: owns the PC, issues single-outstanding word fetches to
//   instruction memory, and hands each fetched word (with its PC and PC+4)
//   to decode over a valid/ready handshake. Redirects retarget fetch and
//   squash whatever is in flight or held. All outputs are registered.
//
// Ports
//   clk, rst            core clock; asynchronous active-high reset
//   redirect_valid/pc   one-cycle redirect pulse and its target (bits [1:0] dropped)
//   imem_req_*          fetch request channel (valid/ready, word address)
//   imem_rsp_*          fetch response beat (always accepted)
//   instr_valid/ready   handshake to decode
//   instr, instr_pc,
//   instr_pc_plus4      held instruction word and its addresses
//   fetch_count         instructions accepted by decode (wraps)
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir;
    logic [31:0] pc_next;

    assign redir   = redirect_pc & 32'hFFFF_FFFC;
    assign pc_next = pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            instr_valid    <= 1'b0;
            instr          <= NOP_INSTR;
            instr_pc       <= RESET_PC;
            instr_pc_plus4 <= RESET_PC + 32'd4;
            fetch_count    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                    if (redirect_valid) begin
                        pc            <= redir;
                        imem_req_addr <= redir;
                    end else begin
                        imem_req_addr <= pc;
                    end
                end

                REQ: begin
                    if (redirect_valid) begin
                        pc <= redir;
                        if (imem_req_ready) begin
                            // Old request was accepted; its response must be dropped.
                            state          <= DRAIN;
                            imem_req_valid <= 1'b0;
                        end else begin
                            imem_req_addr <= redir;
                        end
                    end else if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end

                WAIT: begin
                    if (redirect_valid) begin
                        pc <= redir;
                        if (imem_rsp_valid) begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                            imem_req_addr  <= redir;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem_rsp_valid) begin
                        state          <= HOLD;
                        instr_valid    <= 1'b1;
                        instr          <= imem_rsp_data;
                        instr_pc       <= pc;
                        instr_pc_plus4 <= pc_next;
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        // Squash: the held instruction is never counted.
                        pc             <= redir;
                        instr_valid    <= 1'b0;
                        instr          <= NOP_INSTR;
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= redir;
                    end else if (instr_ready) begin
                        pc             <= pc_next;
                        instr_valid    <= 1'b0;
                        instr          <= NOP_INSTR;
                        fetch_count    <= fetch_count + 32'd1;
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= pc_next;
                    end
                end

                DRAIN: begin
                    // A redirect alone keeps us draining; if the stale beat lands in
                    // the same cycle it is consumed and fetch restarts at the new target.
                    if (imem_rsp_valid) begin
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= redirect_valid ? redir : pc;
                    end
                    if (redirect_valid) pc <= redir;
                end

                default: begin
                    state          <= IDLE;
                    imem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. Inputs are driven 1 ns after each
//   rising edge and outputs are sampled at the same point. The memory is
//   modelled by hand: a response beat arrives one cycle after the WAIT state
//   is entered unless a step says otherwise.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic [31:0] fetch_count;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr",  imem_req_addr,       32'h0);
        chk("rst_instr_vld", 32'(instr_valid),    32'd0);
        chk("rst_instr",     instr,               NOP);
        chk("rst_instr_pc",  instr_pc,            32'h0);
        chk("rst_pc_plus4",  instr_pc_plus4,      32'h4);
        chk("rst_count",     fetch_count,         32'd0);
        rst = 1'b0;

        // Zero-wait streaming: cycle 1 request at 0x0
        tick();
        chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c1_req_addr",  imem_req_addr,       32'h0);
        tick();                                  // cycle 2: WAIT
        chk("c2_req_valid", 32'(imem_req_valid), 32'd0);
        tick();                                  // cycle 3: response beat
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
        tick();                                  // cycle 4: HOLD
        imem_rsp_valid = 1'b0;
        chk("c4_instr_vld", 32'(instr_valid), 32'd1);
        chk("c4_instr",     instr,            32'h0000_0093);
        chk("c4_instr_pc",  instr_pc,         32'h0);
        chk("c4_plus4",     instr_pc_plus4,   32'h4);
        tick();                                  // cycle 5: REQ 0x4
        chk("c5_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c5_req_addr",  imem_req_addr,       32'h4);
        chk("c5_instr_vld", 32'(instr_valid),    32'd0);
        chk("c5_instr_nop", instr,               NOP);
        chk("c5_count",     fetch_count,         32'd1);
        tick();                                  // cycle 6: WAIT
        tick();                                  // cycle 7: response
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0113;
        tick();                                  // cycle 8: HOLD
        imem_rsp_valid = 1'b0;
        chk("c8_instr_pc",  instr_pc,       32'h4);
        chk("c8_plus4",     instr_pc_plus4, 32'h8);
        tick();                                  // cycle 9: REQ 0x8
        chk("c9_count",     fetch_count,   32'd2);
        chk("c9_req_addr",  imem_req_addr, 32'h8);

        // Request back-pressure for 3 cycles at 0x8
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
            chk("bp_req_addr",  imem_req_addr,       32'h8);
        end
        imem_req_ready = 1'b1;
        tick();                                  // WAIT
        chk("bp_wait1_valid", 32'(imem_req_valid), 32'd0);
        instr_ready    = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
        tick();                                  // HOLD
        imem_rsp_valid = 1'b0;
        chk("hold_instr",  instr,          32'h0050_0093);
        chk("hold_pc",     instr_pc,       32'h8);
        chk("hold_plus4",  instr_pc_plus4, 32'hC);

        // Decode stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_vld",   32'(instr_valid),    32'd1);
            chk("stall_instr", instr,               32'h0050_0093);
            chk("stall_pc",    instr_pc,            32'h8);
            chk("stall_plus4", instr_pc_plus4,      32'hC);
            chk("stall_noreq", 32'(imem_req_valid), 32'd0);
        end
        instr_ready = 1'b1;
        tick();                                  // REQ 0xC
        chk("stall_count", fetch_count,   32'd3);
        chk("stall_addr",  imem_req_addr, 32'hC);

        // Redirect to 0x103 in WAIT, stale response 2 cycles later
        tick();                                  // WAIT
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();                                  // DRAIN
        redirect_valid = 1'b0;
        chk("drain_noreq", 32'(imem_req_valid), 32'd0);
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        tick();                                  // REQ 0x100
        imem_rsp_valid = 1'b0;
        chk("rd_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd_req_addr",  imem_req_addr,       32'h100);
        chk("rd_no_instr",  32'(instr_valid),    32'd0);
        tick();                                  // WAIT
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0033;
        tick();                                  // HOLD
        imem_rsp_valid = 1'b0;
        chk("rd_instr",    instr,          32'h0000_0033);
        chk("rd_instr_pc", instr_pc,       32'h100);
        chk("rd_plus4",    instr_pc_plus4, 32'h104);
        chk("rd_count",    fetch_count,    32'd3);

        // Redirect to 0x40 in HOLD with instr_ready the same cycle
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        tick();                                  // REQ 0x40
        redirect_valid = 1'b0;
        chk("sq_count",     fetch_count,         32'd3);
        chk("sq_instr_vld", 32'(instr_valid),    32'd0);
        chk("sq_instr",     instr,               NOP);
        chk("sq_req_valid", 32'(imem_req_valid), 32'd1);
        chk("sq_req_addr",  imem_req_addr,       32'h40);

        // Redirect (no handshake) to 0xFFFF_FFFC, then PC wrap
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk("wr_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick();                                  // WAIT
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_006F;
        tick();                                  // HOLD
        imem_rsp_valid = 1'b0;
        chk("wr_instr_pc", instr_pc,       32'hFFFF_FFFC);
        chk("wr_plus4",    instr_pc_plus4, 32'h0);
        tick();                                  // REQ 0x0
        chk("wr_req_addr0", imem_req_addr, 32'h0);
        chk("wr_count",     fetch_count,   32'd4);
        tick();                                  // WAIT

        // Asynchronous reset mid-WAIT
        rst = 1'b1;
        #1;
        chk("ar_req_valid", 32'(imem_req_valid), 32'd0);
        chk("ar_req_addr",  imem_req_addr,       32'h0);
        chk("ar_instr_vld", 32'(instr_valid),    32'd0);
        chk("ar_instr",     instr,               NOP);
        chk("ar_plus4",     instr_pc_plus4,      32'h4);
        chk("ar_count",     fetch_count,         32'd0);
        tick();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_0BAD;
        tick();                                  // REQ, stray beat ignored
        chk("st_req_valid", 32'(imem_req_valid), 32'd1);
        chk("st_req_addr",  imem_req_addr,       32'h0);
        tick();
        imem_rsp_valid = 1'b0;
        chk("st_instr_vld", 32'(instr_valid), 32'd0);
        chk("st_instr",     instr,            NOP);
        chk("st_req_hold",  32'(imem_req_valid), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
